agc_io_channels: RTL



---
 rtl/agc_io_channels_pkg.sv | 24 ++
 rtl/agc_io_channels_if.sv | 57 +++++
 rtl/agc_io_channels_fifo.sv | 114 +++++++++++
 rtl/agc_io_channels.sv | 70 +++++++
 4 files changed

// File: rtl/agc_io_channels_pkg.sv
// Shared types and channel-map constants for the AGC IO channel bank.
// Channels 0-3 are core-written outputs, 4-7 are peripheral-written inputs.
package agc_io_pkg;

   localparam int NUM_CHAN      = 8;
   localparam int OUT_CHAN_LAST = 3;
   localparam int IN_CHAN_BASE  = 4;

   typedef struct packed {
      logic [1:0]  chan;
      logic [14:0] data;
   } io_event_t;

   // True when a core write selector addresses an output channel.
   function automatic logic is_out_chan(input logic [2:0] sel);
      return sel <= 3'(OUT_CHAN_LAST);
   endfunction

   // Register index of peripheral input channel `sel`.
   function automatic logic [2:0] in_chan_idx(input logic [1:0] sel);
      return 3'(IN_CHAN_BASE) + {1'b0, sel};
   endfunction

endpackage

// File: rtl/agc_io_channels_if.sv
// Bus bundle between the core/peripheral side and the IO channel bank.
// slave is the channel bank, master is whoever drives it.
interface agc_io_channels_if #(
   parameter int DEPTH = 4
);
   import agc_io_pkg::*;

   logic [2:0]             IO_read_sel;
   logic [14:0]            IO_read_data;
   logic [2:0]             IO_write_sel;
   logic [14:0]            IO_write_data;
   logic                   IO_write_en;
   logic                   io_stall;
   logic                   in_valid;
   logic [1:0]             in_sel;
   logic [14:0]            in_data;
   logic                   out_valid;
   logic                   out_ready;
   logic [1:0]             out_chan;
   logic [14:0]            out_data;
   logic [$clog2(DEPTH):0] out_count;

   modport master (
      output IO_read_sel,
      input  IO_read_data,
      output IO_write_sel,
      output IO_write_data,
      output IO_write_en,
      input  io_stall,
      output in_valid,
      output in_sel,
      output in_data,
      input  out_valid,
      output out_ready,
      input  out_chan,
      input  out_data,
      input  out_count
   );

   modport slave (
      input  IO_read_sel,
      output IO_read_data,
      input  IO_write_sel,
      input  IO_write_data,
      input  IO_write_en,
      output io_stall,
      input  in_valid,
      input  in_sel,
      input  in_data,
      output out_valid,
      input  out_ready,
      output out_chan,
      output out_data,
      output out_count
   );

endinterface

// File: rtl/agc_io_channels_fifo.sv
// Output event queue: DEPTH-entry circular FIFO with IO_OUT_FIFO_EN,
// otherwise a single holding register (full whenever it holds an event).
module io_event_fifo
   import agc_io_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   push,
   input  io_event_t              push_data,
   output logic                   full,
   input  logic                   pop,
   output logic                   valid,
   output io_event_t              head,
   output logic [$clog2(DEPTH):0] count
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic do_push;
   logic do_pop;

   assign do_push = push & ~full;
   assign do_pop  = pop & valid;

`ifdef IO_OUT_FIFO_EN

   localparam int AW = $clog2(DEPTH);

   io_event_t       mem_q [DEPTH];
   io_event_t       mem_d [DEPTH];
   logic [AW-1:0]   wr_q, wr_d;
   logic [AW-1:0]   rd_q, rd_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   assign full  = (cnt_q == CW'(DEPTH));
   assign valid = (cnt_q != '0);
   assign head  = mem_q[rd_q];
   assign count = cnt_q;

   // Next-state: write at tail, advance head, count tracks the net change.
   always_comb begin
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (do_push) begin
         mem_d[wr_q] = push_data;
         wr_d        = wr_q + 1'b1;
      end
      if (do_pop) begin
         rd_d = rd_q + 1'b1;
      end
      unique case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   // Queue state; reset discards every entry and zeroes the head.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

`else

   io_event_t hold_q, hold_d;
   logic      vld_q, vld_d;

   assign full  = vld_q;
   assign valid = vld_q;
   assign head  = hold_q;
   assign count = vld_q ? CW'(1) : '0;

   // A push only lands when empty, so it never overlaps a pop.
   always_comb begin
      hold_d = hold_q;
      vld_d  = vld_q & ~do_pop;
      if (do_push) begin
         hold_d = push_data;
         vld_d  = 1'b1;
      end
   end

   // Single-entry holding register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hold_q <= '0;
         vld_q  <= 1'b0;
      end else begin
         hold_q <= hold_d;
         vld_q  <= vld_d;
      end
   end

`endif

endmodule

// File: rtl/agc_io_channels.sv
// AGC IO channel register bank with an output event queue toward the
// peripheral side. Build option: IO_OUT_FIFO_EN selects a DEPTH-entry queue.
module agc_io_channels
   import agc_io_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input logic                clock,
   input logic                reset,
   agc_io_channels_if.slave   io
);

   logic [14:0]            chan_q [NUM_CHAN];
   logic [14:0]            chan_d [NUM_CHAN];
   logic                   out_wr;
   logic                   fifo_full;
   logic                   fifo_valid;
   io_event_t              push_ev;
   io_event_t              head_ev;
   logic [$clog2(DEPTH):0] fifo_count;

   assign out_wr  = io.IO_write_en & is_out_chan(io.IO_write_sel);
   assign push_ev = '{chan: io.IO_write_sel[1:0], data: io.IO_write_data};

   // Output writes update the register only when their event is queued.
   always_comb begin
      chan_d = chan_q;
      if (out_wr && !fifo_full) begin
         chan_d[io.IO_write_sel] = io.IO_write_data;
      end
      if (io.in_valid) begin
         chan_d[in_chan_idx(io.in_sel)] = io.in_data;
      end
   end

   // Channel registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_CHAN; i++) begin
            chan_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_CHAN; i++) begin
            chan_q[i] <= chan_d[i];
         end
      end
   end

   io_event_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (out_wr),
      .push_data (push_ev),
      .full      (fifo_full),
      .pop       (io.out_ready),
      .valid     (fifo_valid),
      .head      (head_ev),
      .count     (fifo_count)
   );

   assign io.io_stall     = out_wr & fifo_full;
   assign io.IO_read_data = chan_q[io.IO_read_sel];
   assign io.out_valid    = fifo_valid;
   assign io.out_chan     = head_ev.chan;
   assign io.out_data     = head_ev.data;
   assign io.out_count    = fifo_count;

endmodule
